// File: rtl/uart_pkg.sv
// Shared constants for the buffered UART transmitter: FSM state encoding,
// frame shape and the baud divider helper.
package uart_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit; the fractional part is discarded.
    function automatic int baud_div(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered count/full/empty and a registered read port:
// rd_data holds the popped entry from the cycle after rd_en until the next pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nx_s;
    logic             full_r;
    logic             empty_r;
    logic [WIDTH-1:0] rd_data_r;
    logic             push_s;
    logic             pop_s;

    // full is the pre-pop view, so a write into a full FIFO is dropped even if a pop coincides
    assign push_s = wr_en && !full_r;
    assign pop_s  = rd_en && !empty_r;

    // Next occupancy from this cycle's accepted push/pop
    always_comb begin
        count_nx_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nx_s = count_r + CW'(1);
            2'b01:   count_nx_s = count_r - CW'(1);
            default: count_nx_s = count_r;
        endcase
    end

    // Pointers, status flags and read register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            rd_data_r <= {WIDTH{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r  <= rd_ptr_r + AW'(1);
                rd_data_r <= mem_r[rd_ptr_r];
            end
            count_r <= count_nx_s;
            full_r  <= (count_nx_s == CNT_FULL);
            empty_r <= (count_nx_s == {CW{1'b0}});
        end
    end

    // Storage array
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = rd_data_r;
    assign full    = full_r;
    assign empty   = empty_r;
    assign count   = count_r;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are serialised
// back-to-back with a single idle clock between frames.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             wr_data,
    input  logic                   wr_en,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   busy,
    output logic                   tx
);

    localparam int DIV = baud_div(CLK_HZ, BAUD);
    localparam int BW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BW-1:0] BCNT_LAST = BW'(DIV - 1);

    logic             fifo_empty_s;
    logic             fifo_rd_en_s;
    logic [7:0]       fifo_rd_data_s;
    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [BW-1:0]    bcnt_r;
    logic [BW-1:0]    bcnt_nx_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nx_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nx_s;
    logic             bit_done_s;
    logic             tx_nx_s;
    logic             tx_r;
    logic             busy_r;
    logic             overflow_r;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (fifo_rd_en_s),
        .rd_data (fifo_rd_data_s),
        .full    (full),
        .empty   (fifo_empty_s),
        .count   (count)
    );

    assign bit_done_s = (bcnt_r == BCNT_LAST);

    // Frame sequencing; the popped byte lands in the FIFO read register during START
    always_comb begin
        state_nx_s   = state_r;
        bcnt_nx_s    = bcnt_r;
        bit_idx_nx_s = bit_idx_r;
        shift_nx_s   = shift_r;
        fifo_rd_en_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                bcnt_nx_s = {BW{1'b0}};
                if (!fifo_empty_s) begin
                    fifo_rd_en_s = 1'b1;
                    bit_idx_nx_s = 3'd0;
                    state_nx_s   = ST_START;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    bcnt_nx_s  = {BW{1'b0}};
                    shift_nx_s = fifo_rd_data_s;
                    state_nx_s = ST_DATA;
                end else begin
                    bcnt_nx_s = bcnt_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    bcnt_nx_s  = {BW{1'b0}};
                    shift_nx_s = {1'b0, shift_r[7:1]};
                    if (bit_idx_r == 3'(DATA_BITS - 1)) begin
                        state_nx_s = ST_STOP;
                    end else begin
                        bit_idx_nx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bcnt_nx_s = bcnt_r + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    bcnt_nx_s  = {BW{1'b0}};
                    state_nx_s = ST_IDLE;
                end else begin
                    bcnt_nx_s = bcnt_r + BW'(1);
                end
            end
            default: begin
                bcnt_nx_s  = {BW{1'b0}};
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // Line level derived from the next state so tx leaves a flop glitch-free
    always_comb begin
        tx_nx_s = 1'b1;
        case (state_nx_s)
            ST_IDLE:  tx_nx_s = 1'b1;
            ST_START: tx_nx_s = 1'b0;
            ST_DATA:  tx_nx_s = shift_nx_s[0];
            ST_STOP:  tx_nx_s = 1'b1;
            default:  tx_nx_s = 1'b1;
        endcase
    end

    // Engine registers and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            bcnt_r     <= {BW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r    <= state_nx_s;
            bcnt_r     <= bcnt_nx_s;
            bit_idx_r  <= bit_idx_nx_s;
            shift_r    <= shift_nx_s;
            tx_r       <= tx_nx_s;
            busy_r     <= (state_nx_s != ST_IDLE);
            overflow_r <= wr_en && full;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed + randomized bench for uart_tx_buffered: a line decoder turns tx back
// into bytes and a byte queue of accepted pushes is the reference.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 1000;
    localparam int BAUD   = 100;
    localparam int DEPTH  = 4;
    localparam int DIV    = CLK_HZ / BAUD;

    typedef logic [7:0] bq_t[$];

    logic       clk;
    logic       reset;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       busy;
    logic       tx;

    int passed = 0;
    int total  = 0;
    int n_fail = 0;

    uart_tx_buffered #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .full     (full),
        .count    (count),
        .overflow (overflow),
        .busy     (busy),
        .tx       (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line decoder: samples mid-bit on the falling clock edge
    logic [7:0] rx_q[$];
    int         start_q[$];
    bit         frm_q[$];
    int         cyc = 0;
    bit         rx_act = 1'b0;
    int         rx_t;
    int         rx_start;
    logic [7:0] rx_b;
    bit         rx_ok;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (reset !== 1'b1) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx === 1'b0) begin
                rx_act = 1'b1; rx_t = 0; rx_b = 8'h00; rx_ok = 1'b1; rx_start = cyc;
            end
        end else begin
            rx_t = rx_t + 1;
            if (rx_t == DIV / 2) begin
                if (tx !== 1'b0) rx_ok = 1'b0;
            end else if (rx_t > DIV && rx_t < 9 * DIV && (rx_t % DIV) == DIV / 2) begin
                rx_b = {tx, rx_b[7:1]};
            end else if (rx_t == 9 * DIV + DIV / 2) begin
                if (tx !== 1'b1) rx_ok = 1'b0;
                rx_q.push_back(rx_b);
                start_q.push_back(rx_start);
                frm_q.push_back(rx_ok);
                rx_act = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        step();
        wr_en   = 1'b0;
    endtask

    // Expected line level for bit slot k of a frame carrying b
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    task automatic wait_drain(input string tag);
        int n = 0;
        while (!(busy === 1'b0 && count === 3'd0) && n < 3000) begin
            step();
            n++;
        end
        check({tag, ".drain"}, 32'(n < 3000), 32'd1);
    endtask

    task automatic check_rx(input string tag, input bq_t exp, input bit b2b);
        check({tag, ".nbytes"}, rx_q.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx_q.size(); i++) begin
            check({tag, ".byte"}, rx_q[i], exp[i]);
            check({tag, ".framing"}, frm_q[i], 1);
            if (b2b && i > 0) check({tag, ".gap"}, start_q[i] - start_q[i-1], 10 * DIV + 1);
        end
        rx_q.delete();
        start_q.delete();
        frm_q.delete();
    endtask

    initial begin
        bq_t        exp;
        logic [7:0] v [7];
        logic [7:0] x;
        bit         all_hi;
        int         n;
        int         nb;

        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        #2 reset = 1'b0;
        repeat (3) step();
        check("rst.tx", tx, 1);
        check("rst.busy", busy, 0);
        check("rst.full", full, 0);
        check("rst.count", count, 0);
        check("rst.overflow", overflow, 0);
        reset = 1'b1;
        repeat (2) step();
        check("idle.tx", tx, 1);

        // Single byte 0x41: start bit two cycles after the push
        push(8'h41);
        check("t1.count", count, 1);
        check("t1.tx_pre", tx, 1);
        check("t1.busy_pre", busy, 0);
        step();
        for (int c = 0; c < 10 * DIV; c++) begin
            check("t1.tx", tx, frame_bit(8'h41, c / DIV));
            check("t1.busy", busy, 1);
            step();
        end
        check("t1.busy_end", busy, 0);
        check("t1.tx_end", tx, 1);
        exp = {8'h41};
        check_rx("t1", exp, 1'b0);

        // Three consecutive pushes go out back-to-back
        push(8'h55);
        check("t2.count_a", count, 1);
        push(8'hAA);
        check("t2.count_b", count, 1);
        push(8'h0F);
        check("t2.count_c", count, 2);
        check("t2.busy", busy, 1);
        wait_drain("t2");
        exp = {8'h55, 8'hAA, 8'h0F};
        check_rx("t2", exp, 1'b1);

        // Fill while a frame is on the line, overflow, then push into full at the pop cycle
        for (int i = 0; i < 7; i++) v[i] = 8'($urandom);
        push(v[0]);
        step();
        for (int i = 1; i < 5; i++) push(v[i]);
        check("t3.count_full", count, 4);
        check("t3.full", full, 1);
        push(v[5]);
        check("t3.overflow", overflow, 1);
        check("t3.count_hold", count, 4);
        step();
        check("t3.overflow_pulse", overflow, 0);
        n = 0;
        while (busy !== 1'b0 && n < 300) begin
            step();
            n++;
        end
        check("t3.idle_reached", 32'(n < 300), 1);
        check("t3.full_at_pop", full, 1);
        push(v[6]);
        check("t3.overflow_pop", overflow, 1);
        check("t3.count_pop", count, 3);
        check("t3.full_pop", full, 0);
        check("t3.busy_pop", busy, 1);
        step();
        check("t3.overflow_clr", overflow, 0);
        wait_drain("t3");
        exp = {v[0], v[1], v[2], v[3], v[4]};
        check_rx("t3", exp, 1'b1);

        // Random bursts with random spacing
        for (int b = 0; b < 5; b++) begin
            exp.delete();
            nb = $urandom_range(1, DEPTH);
            for (int j = 0; j < nb; j++) begin
                x = 8'($urandom);
                exp.push_back(x);
                push(x);
                repeat ($urandom_range(0, 40)) step();
            end
            wait_drain("t4");
            check_rx("t4", exp, 1'b0);
        end

        // Reset during data bit 4 aborts the frame and empties the queue
        x = 8'($urandom) & 8'hEF;
        push(x);
        push(8'($urandom));
        push(8'($urandom));
        repeat (51) step();
        check("t5.bit4", tx, 0);
        check("t5.busy", busy, 1);
        check("t5.count", count, 2);
        #2 reset = 1'b0;
        #1;
        check("t5.tx_async", tx, 1);
        check("t5.busy_async", busy, 0);
        check("t5.count_async", count, 0);
        check("t5.full_async", full, 0);
        repeat (3) step();
        reset  = 1'b1;
        all_hi = 1'b1;
        repeat (250) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) all_hi = 1'b0;
        end
        check("t5.line_idle", all_hi, 1);
        check("t5.count_after", count, 0);
        check("t5.no_rx", rx_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
